// File: rtl/switch_in_arbiter_if.sv
// Port-side bundle of the switch input arbiter: per-port request/ack/flit lanes,
// queue full flag in, queue write strobe and flit out, plus grant status.
interface switch_in_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int NP       = PORTS_NUM + 1;
  localparam int IDX_W    = $clog2(NP);

  logic [NP-1:0]          in_r;
  logic [BUS_SIZE*NP-1:0] data_i;
  logic                   is_full;
  logic                   wr_req;
  logic [BUS_SIZE-1:0]    data_o;
  logic [NP-1:0]          in_w;
  logic [IDX_W-1:0]       grant_idx;
  logic                   busy;

  modport master (
    output in_r, data_i, is_full,
    input  wr_req, data_o, in_w, grant_idx, busy
  );

  modport slave (
    input  in_r, data_i, is_full,
    output wr_req, data_o, in_w, grant_idx, busy
  );
endinterface

// File: rtl/switch_in_arbiter.sv
// Round-robin arbiter feeding one flit per grant into the shared queue; request to write
// strobe in 1 cycle, no grant while is_full, ack held until the sender drops its request.
module switch_in_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4
) (
  input logic               clk,
  input logic               a_rst,
  switch_in_arbiter_if.slave bus
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int NP       = PORTS_NUM + 1;
  localparam int IDX_W    = $clog2(NP);
  localparam logic [NP-1:0] ONE_HOT0 = NP'(1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    grant_q;
  logic                wr_req_q;
  logic                busy_q;
  logic [BUS_SIZE-1:0] data_q;
  logic [NP-1:0]       in_w_q;

  logic [IDX_W-1:0]    win_d;
  logic                any_req_d;
  logic [BUS_SIZE-1:0] flit [NP];

  for (genvar i = 0; i < NP; i++) begin : g_flit
    assign flit[i] = bus.data_i[i*BUS_SIZE +: BUS_SIZE];
  end

  // Walk the search order backwards so the last hit is the first requester after grant_q.
  always_comb begin
    int t;
    win_d     = '0;
    t         = 0;
    any_req_d = |bus.in_r;
    for (int k = NP; k >= 1; k--) begin
      t = int'(grant_q) + k;
      if (t >= NP) t = t - NP;
      if (bus.in_r[t]) win_d = IDX_W'(t);
    end
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state_q  <= IDLE;
      grant_q  <= IDX_W'(PORTS_NUM);
      wr_req_q <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
      in_w_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.is_full && any_req_d) begin
            data_q   <= flit[win_d];
            wr_req_q <= 1'b1;
            in_w_q   <= ONE_HOT0 << win_d;
            grant_q  <= win_d;
            busy_q   <= 1'b1;
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          wr_req_q <= 1'b0;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (!bus.in_r[grant_q]) begin
            in_w_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wr_req    = wr_req_q;
  assign bus.data_o    = data_q;
  assign bus.in_w      = in_w_q;
  assign bus.grant_idx = grant_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_switch_in_arbiter.sv
// Bench for switch_in_arbiter: directed handshake scenarios plus randomized senders
// checked against an edge-level ownership/round-robin model.
module tb_switch_in_arbiter;
  localparam int DS = 32;
  localparam int AS = 4;
  localparam int PN = 4;
  localparam int N  = PN + 1;
  localparam int BW = DS + AS + 1;

  logic clk = 1'b0;
  logic a_rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  switch_in_arbiter_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN)) bus();

  switch_in_arbiter #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN)) dut (
    .clk  (clk),
    .a_rst(a_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    a_rst       = 1'b1;
    bus.in_r    = '0;
    bus.is_full = 1'b0;
    tick();
    tick();
    a_rst = 1'b0;
  endtask

  task automatic drain();
    bus.in_r    = '0;
    bus.is_full = 1'b0;
    repeat (4) tick();
  endtask

  task automatic set_flit(input int p, input logic [BW-1:0] f);
    bus.data_i[p*BW +: BW] = f;
  endtask

  function automatic logic [BW-1:0] rnd_flit();
    return BW'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL reset_wr_req: got %b want 0", bus.wr_req); end
    n_cmp++; if (bus.in_w !== 5'b0) begin n_err++; $display("FAIL reset_in_w: got %b want 00000", bus.in_w); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.grant_idx !== 3'd4) begin n_err++; $display("FAIL reset_grant_idx: got %0d want 4", bus.grant_idx); end
    n_cmp++; if (bus.data_o !== '0) begin n_err++; $display("FAIL reset_data_o: got %h want 0", bus.data_o); end
  endtask

  task automatic test_single();
    logic [BW-1:0] f;
    f = 37'h1A5A5A5A5;
    set_flit(0, f);
    bus.in_r = 5'b00001;
    tick();
    n_cmp++; if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL single_wr_req: got %b want 1", bus.wr_req); end
    n_cmp++; if (bus.data_o !== f) begin n_err++; $display("FAIL single_data_o: got %h want %h", bus.data_o, f); end
    n_cmp++; if (bus.in_w !== 5'b00001) begin n_err++; $display("FAIL single_in_w: got %b want 00001", bus.in_w); end
    n_cmp++; if (bus.grant_idx !== 3'd0) begin n_err++; $display("FAIL single_grant_idx: got %0d want 0", bus.grant_idx); end
    tick();
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL single_wr_one_cycle: got %b want 0", bus.wr_req); end
    n_cmp++; if (bus.in_w !== 5'b00001) begin n_err++; $display("FAIL single_in_w_hold: got %b want 00001", bus.in_w); end
    n_cmp++; if (bus.data_o !== f) begin n_err++; $display("FAIL single_data_keep: got %h want %h", bus.data_o, f); end
    bus.in_r = 5'b00000;
    tick();
    n_cmp++; if (bus.in_w !== 5'b00000) begin n_err++; $display("FAIL single_in_w_fall: got %b want 00000", bus.in_w); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", bus.busy); end
    drain();
  endtask

  task automatic test_round_robin();
    logic [BW-1:0] fl [N];
    int ph [N];
    int gq [$];
    int gc [$];
    int ep;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      fl[i] = rnd_flit();
      set_flit(i, fl[i]);
      ph[i] = 0;
    end
    bus.in_r = '1;
    for (int t = 0; t < 40 && gq.size() < 6; t++) begin
      tick();
      if (bus.wr_req === 1'b1) begin
        ep = gq.size() % N;
        n_cmp++; if (bus.data_o !== fl[ep]) begin n_err++; $display("FAIL rr_data_o: got %h want %h", bus.data_o, fl[ep]); end
        gq.push_back(int'(bus.grant_idx));
        gc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
        case (ph[i])
          0: if (bus.in_w[i] === 1'b1) ph[i] = 1;
          1: begin bus.in_r[i] = 1'b0; ph[i] = 2; end
          default: begin bus.in_r[i] = 1'b1; ph[i] = 0; end
        endcase
      end
    end
    n_cmp++; if (gq.size() != 6) begin n_err++; $display("FAIL rr_grant_count: got %0d want 6", gq.size()); end
    for (int k = 0; k < gq.size(); k++) begin
      n_cmp++; if (gq[k] != k % N) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gq[k], k % N); end
      if (k > 0) begin
        n_cmp++; if (gc[k] - gc[k-1] != 3) begin n_err++; $display("FAIL rr_spacing[%0d]: got %0d want 3", k, gc[k] - gc[k-1]); end
      end
    end
    drain();
  endtask

  task automatic test_full();
    apply_reset();
    bus.is_full = 1'b1;
    bus.in_r    = 5'b10010;
    repeat (10) begin
      tick();
      n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL full_wr_req: got %b want 0", bus.wr_req); end
      n_cmp++; if (bus.in_w !== 5'b0) begin n_err++; $display("FAIL full_in_w: got %b want 00000", bus.in_w); end
    end
    bus.is_full = 1'b0;
    tick();
    n_cmp++; if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL full_release_wr: got %b want 1", bus.wr_req); end
    n_cmp++; if (bus.grant_idx !== 3'd1) begin n_err++; $display("FAIL full_release_idx: got %0d want 1", bus.grant_idx); end
    n_cmp++; if (bus.in_w !== 5'b00010) begin n_err++; $display("FAIL full_release_in_w: got %b want 00010", bus.in_w); end
    drain();
  endtask

  task automatic test_hold();
    apply_reset();
    for (int i = 0; i < N; i++) set_flit(i, rnd_flit());
    bus.in_r = 5'b01000;
    tick();
    n_cmp++; if (bus.grant_idx !== 3'd3) begin n_err++; $display("FAIL hold_grant3: got %0d want 3", bus.grant_idx); end
    bus.in_r = 5'b11100;
    repeat (7) begin
      tick();
      n_cmp++; if (bus.in_w !== 5'b01000) begin n_err++; $display("FAIL hold_in_w: got %b want 01000", bus.in_w); end
      n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL hold_extra_wr: got %b want 0", bus.wr_req); end
    end
    bus.in_r = 5'b10100;
    tick();
    n_cmp++; if (bus.in_w !== 5'b0) begin n_err++; $display("FAIL hold_release: got %b want 00000", bus.in_w); end
    tick();
    n_cmp++; if (bus.wr_req !== 1'b1) begin n_err++; $display("FAIL hold_next_wr: got %b want 1", bus.wr_req); end
    n_cmp++; if (bus.grant_idx !== 3'd4) begin n_err++; $display("FAIL hold_next_idx: got %0d want 4", bus.grant_idx); end
    n_cmp++; if (bus.in_w !== 5'b10000) begin n_err++; $display("FAIL hold_next_in_w: got %b want 10000", bus.in_w); end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.in_r = 5'b00100;
    tick();
    n_cmp++; if (bus.grant_idx !== 3'd2) begin n_err++; $display("FAIL rstmid_grant: got %0d want 2", bus.grant_idx); end
    tick();
    a_rst = 1'b1;
    tick();
    n_cmp++; if (bus.in_w !== 5'b0) begin n_err++; $display("FAIL rstmid_in_w: got %b want 00000", bus.in_w); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.grant_idx !== 3'd4) begin n_err++; $display("FAIL rstmid_idx: got %0d want 4", bus.grant_idx); end
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL rstmid_wr: got %b want 0", bus.wr_req); end
    a_rst    = 1'b0;
    bus.in_r = 5'b11111;
    tick();
    n_cmp++; if (bus.grant_idx !== 3'd0) begin n_err++; $display("FAIL rstmid_next_idx: got %0d want 0", bus.grant_idx); end
    n_cmp++; if (bus.in_w !== 5'b00001) begin n_err++; $display("FAIL rstmid_next_in_w: got %b want 00001", bus.in_w); end
    drain();
  endtask

  task automatic test_pulse();
    int nw;
    int nin;
    nw  = 0;
    nin = 0;
    bus.in_r = 5'b00100;
    tick();
    bus.in_r = 5'b00000;
    if (bus.wr_req === 1'b1) nw++;
    if (bus.in_w[2] === 1'b1) nin++;
    repeat (5) begin
      tick();
      if (bus.wr_req === 1'b1) nw++;
      if (bus.in_w[2] === 1'b1) nin++;
    end
    n_cmp++; if (nw != 1) begin n_err++; $display("FAIL pulse_wr_count: got %0d want 1", nw); end
    n_cmp++; if (nin != 2) begin n_err++; $display("FAIL pulse_in_w_cycles: got %0d want 2", nin); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL pulse_idle: got %b want 0", bus.busy); end
    drain();
  endtask

  task automatic test_random();
    int            cd [N];
    logic          m_open;
    int            m_owner;
    int            m_age;
    int            m_last;
    int            c;
    logic          exp_wr;
    logic          exp_busy;
    logic [N-1:0]  exp_in_w;
    logic [BW-1:0] exp_data;
    apply_reset();
    m_open   = 1'b0;
    m_owner  = 0;
    m_age    = 0;
    m_last   = PN;
    exp_busy = 1'b0;
    exp_in_w = '0;
    exp_data = '0;
    for (int i = 0; i < N; i++) cd[i] = -1;
    for (int t = 0; t < 600; t++) begin
      // Model: one owner at a time; it gives up the port on the second or later edge
      // that sees its request low. A free arbiter picks the next requester after the last winner.
      exp_wr = 1'b0;
      if (m_open) begin
        if (m_age >= 1 && bus.in_r[m_owner] == 1'b0) begin
          m_open   = 1'b0;
          exp_in_w = '0;
          exp_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else if (!bus.is_full && bus.in_r != '0) begin
        c = -1;
        for (int k = 1; k <= N; k++)
          if (c < 0 && bus.in_r[(m_last + k) % N]) c = (m_last + k) % N;
        exp_wr      = 1'b1;
        exp_data    = bus.data_i[c*BW +: BW];
        exp_in_w    = '0;
        exp_in_w[c] = 1'b1;
        exp_busy    = 1'b1;
        m_last      = c;
        m_owner     = c;
        m_age       = 0;
        m_open      = 1'b1;
      end
      tick();
      n_cmp++; if (bus.wr_req !== exp_wr) begin n_err++; $display("FAIL rand_wr_req @%0d: got %b want %b", cyc, bus.wr_req, exp_wr); end
      n_cmp++; if (bus.in_w !== exp_in_w) begin n_err++; $display("FAIL rand_in_w @%0d: got %b want %b", cyc, bus.in_w, exp_in_w); end
      n_cmp++; if (bus.grant_idx !== 3'(m_last)) begin n_err++; $display("FAIL rand_grant_idx @%0d: got %0d want %0d", cyc, bus.grant_idx, m_last); end
      n_cmp++; if (bus.busy !== exp_busy) begin n_err++; $display("FAIL rand_busy @%0d: got %b want %b", cyc, bus.busy, exp_busy); end
      n_cmp++; if (bus.data_o !== exp_data) begin n_err++; $display("FAIL rand_data_o @%0d: got %h want %h", cyc, bus.data_o, exp_data); end
      bus.is_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (bus.in_r[i]) begin
          if (cd[i] < 0 && bus.in_w[i] === 1'b1) cd[i] = int'($urandom_range(0, 2));
          if (cd[i] == 0) begin
            bus.in_r[i] = 1'b0;
            cd[i]       = -1;
          end else if (cd[i] > 0) begin
            cd[i]--;
          end
        end else if (bus.in_w[i] !== 1'b1 && $urandom_range(0, 2) == 0) begin
          set_flit(i, rnd_flit());
          bus.in_r[i] = 1'b1;
        end
      end
    end
    drain();
  endtask

  initial begin
    a_rst       = 1'b1;
    bus.in_r    = '0;
    bus.is_full = 1'b0;
    bus.data_i  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_hold();
    test_reset_mid();
    test_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
